// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - radix-2 restoring divider, one quotient bit per clock
// Unsigned/signed truncating division with start/busy/done handshake and divide-by-zero flag.
module seq_divider #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Res,
  output logic [WIDTH-1:0] Rem,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, rem, dvs;
  logic             qneg, rneg;

  logic             use_signed, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   rem_sh, diff;
  logic             fits, last_step;
  logic [WIDTH-1:0] q_step, r_step;
  logic             unused_diff_msb;

  assign use_signed = SIGNED_EN && signed_mode;
  assign sa         = use_signed & A[WIDTH-1];
  assign sb         = use_signed & B[WIDTH-1];
  assign mag_a      = sa ? -A : A;
  assign mag_b      = sb ? -B : B;

  // Magnitudes are unsigned WIDTH-bit values, so 2^(WIDTH-1) from the most-negative input still fits.
  assign rem_sh          = {rem, dvd[WIDTH-1]};
  assign diff            = rem_sh - {1'b0, dvs};
  assign fits            = rem_sh >= {1'b0, dvs};
  assign q_step          = {dvd[WIDTH-2:0], fits};
  assign r_step          = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign last_step       = (cnt == CW'(WIDTH - 1));
  assign unused_diff_msb = diff[WIDTH];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (B == '0) ? DONE : CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dvd      <= '0;
      rem      <= '0;
      dvs      <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      Res      <= '0;
      Rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd  <= mag_a;
            dvs  <= mag_b;
            rem  <= '0;
            cnt  <= '0;
            qneg <= sa ^ sb;
            rneg <= sa;
            if (B == '0) begin
              Res      <= '1;
              Rem      <= A;
              div_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          dvd <= q_step;
          rem <= r_step;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            // Remainder follows the dividend's sign, giving truncation toward zero.
            Res      <= qneg ? -q_step : q_step;
            Rem      <= rneg ? -r_step : r_step;
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
